// File: rtl/jtframe_pll_supervisor.sv
// jtframe_pll_supervisor
// ----------------------
// Sequences the reset of a PLL and of the logic it clocks. The PLL is held in reset for
// PLL_RST_LEN cycles. The supervisor then waits for a lock that stays solid for LOCK_STABLE
// consecutive cycles before releasing sys_rst. Loss of lock while running starts a new PLL
// reset pulse and bumps a saturating relock counter.
//
// Optional feature (macro JTFRAME_PLL_RETRY_EN): if RUN is not reached within LOCK_TIMEOUT
// cycles of pll_rst release, the PLL is reset again and the retry is counted.
//
// Ports
//   clk        : free-running board reference clock; all logic runs in this domain
//   rst_n      : asynchronous active-low reset
//   locked     : PLL lock, asynchronous to clk (double-flopped before use)
//   pll_rst    : active-high reset to the PLL
//   sys_rst    : active-high reset for PLL-clocked logic; low only in RUN
//   relock_cnt : saturating count of PLL re-reset events (the power-on pulse is not counted)
//   pll_ok     : high exactly while in RUN
module jtframe_pll_supervisor #(
    parameter int unsigned PLL_RST_LEN  = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 1 << 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic [7:0] relock_cnt,
    output logic       pll_ok
);

    localparam int unsigned RST_W = $clog2(PLL_RST_LEN);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_LEN - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);

    if (PLL_RST_LEN < 2 || LOCK_STABLE < 2 || LOCK_TIMEOUT < LOCK_STABLE + 4) begin : g_bad_params
        $error("jtframe_pll_supervisor: parameter out of range");
    end

    typedef enum logic [1:0] {
        StPllRst,
        StWait,
        StStable,
        StRun
    } state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic             r_sync1;
    logic             r_lock_s;
    logic [RST_W-1:0] r_rst_cnt;
    logic [RST_W-1:0] w_rst_cnt_d;
    logic [STB_W-1:0] r_stb_cnt;
    logic [STB_W-1:0] w_stb_cnt_d;
    logic [7:0]       r_relock;
    logic             w_relock_inc;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_pll_ok;

`ifdef JTFRAME_PLL_RETRY_EN
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_cnt_d;
    logic             w_tmo_hit;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_rst_cnt_d  = r_rst_cnt;
        w_stb_cnt_d  = r_stb_cnt;
        w_relock_inc = 1'b0;
`ifdef JTFRAME_PLL_RETRY_EN
        w_tmo_cnt_d  = r_tmo_cnt;
        // Hit on the cycle the count would reach LOCK_TIMEOUT, so WAIT+STABLE last exactly
        // LOCK_TIMEOUT cycles and the counter never exceeds LOCK_TIMEOUT.
        w_tmo_hit    = (r_tmo_cnt == TMO_LAST);
`endif
        unique case (r_state)
            StPllRst: begin
                w_stb_cnt_d = '0;
`ifdef JTFRAME_PLL_RETRY_EN
                w_tmo_cnt_d = '0;
`endif
                if (r_rst_cnt == RST_LAST) begin
                    w_state_d   = StWait;
                    w_rst_cnt_d = '0;
                end else begin
                    w_rst_cnt_d = r_rst_cnt + 1'b1;
                end
            end
            StWait: begin
`ifdef JTFRAME_PLL_RETRY_EN
                w_tmo_cnt_d = r_tmo_cnt + 1'b1;
`endif
                if (r_lock_s) begin
                    w_state_d   = StStable;
                    w_stb_cnt_d = '0;
                end
`ifdef JTFRAME_PLL_RETRY_EN
                else if (w_tmo_hit) begin
                    w_state_d    = StPllRst;
                    w_relock_inc = 1'b1;
                end
`endif
            end
            StStable: begin
`ifdef JTFRAME_PLL_RETRY_EN
                w_tmo_cnt_d = r_tmo_cnt + 1'b1;
`endif
                // Reaching RUN takes priority over a timeout on the same edge.
                if (r_lock_s && r_stb_cnt == STB_LAST) begin
                    w_state_d = StRun;
                end
`ifdef JTFRAME_PLL_RETRY_EN
                else if (w_tmo_hit) begin
                    w_state_d    = StPllRst;
                    w_relock_inc = 1'b1;
                end
`endif
                else if (!r_lock_s) begin
                    w_state_d   = StWait;
                    w_stb_cnt_d = '0;
                end else begin
                    w_stb_cnt_d = r_stb_cnt + 1'b1;
                end
            end
            StRun: begin
                if (!r_lock_s) begin
                    w_state_d    = StPllRst;
                    w_relock_inc = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_lock_s  <= 1'b0;
            r_state   <= StPllRst;
            r_rst_cnt <= '0;
            r_stb_cnt <= '0;
            r_relock  <= 8'd0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_pll_ok  <= 1'b0;
        end else begin
            r_sync1   <= locked;
            r_lock_s  <= r_sync1;
            r_state   <= w_state_d;
            r_rst_cnt <= w_rst_cnt_d;
            r_stb_cnt <= w_stb_cnt_d;
            if (w_relock_inc && r_relock != 8'hFF) begin
                r_relock <= r_relock + 8'd1;
            end
            // Outputs are decoded from the next state so they change on the transition edge.
            r_pll_rst <= (w_state_d == StPllRst);
            r_sys_rst <= (w_state_d != StRun);
            r_pll_ok  <= (w_state_d == StRun);
        end
    end

`ifdef JTFRAME_PLL_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_d;
        end
    end
`endif

    assign pll_rst    = r_pll_rst;
    assign sys_rst    = r_sys_rst;
    assign pll_ok     = r_pll_ok;
    assign relock_cnt = r_relock;

endmodule

// File: tb/tb_jtframe_pll_supervisor.sv
// Bench for jtframe_pll_supervisor (PLL_RST_LEN=4, LOCK_STABLE=8, LOCK_TIMEOUT=32).
// Reference model: pll_rst is a deadline in edge numbers, RUN is reached after LOCK_STABLE+1
// consecutive synchronised-lock samples following the pulse, and a retry fires LOCK_TIMEOUT
// edges after the pulse ends.
module tb_jtframe_pll_supervisor;

    localparam int LEN = 4;
    localparam int LS  = 8;
    localparam int LT  = 32;
`ifdef JTFRAME_PLL_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       pll_ok;
    logic [7:0] relock_cnt;
    logic [10:0] dut_vec;

    jtframe_pll_supervisor #(
        .PLL_RST_LEN (LEN),
        .LOCK_STABLE (LS),
        .LOCK_TIMEOUT(LT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .locked    (locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .relock_cnt(relock_cnt),
        .pll_ok    (pll_ok)
    );

    always #5 clk = ~clk;
    assign dut_vec = {pll_rst, sys_rst, pll_ok, relock_cnt};

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_n;
    int m_rst_until;
    int m_streak;
    int m_relock;
    bit m_run;
    bit m_q[$];
    int rises;
    bit prev_pr;

    localparam logic [10:0] RST_VEC = {1'b1, 1'b1, 1'b0, 8'd0};

    function automatic void model_reset();
        m_n = 0;
        m_rst_until = LEN;
        m_streak = 0;
        m_relock = 0;
        m_run = 1'b0;
        m_q.delete();
        m_q.push_back(1'b0);
        m_q.push_back(1'b0);
        prev_pr = 1'b1;
    endfunction

    function automatic void bump();
        if (m_relock < 255) m_relock++;
    endfunction

    function automatic void model_edge();
        bit ls;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_n++;
        m_q.push_back(locked);
        ls = m_q[m_q.size() - 3];  // lock value as seen after the two-flop synchroniser
        if (m_q.size() > 8) void'(m_q.pop_front());
        if (m_n <= m_rst_until) begin
            m_streak = 0;
        end else if (m_run) begin
            if (!ls) begin
                m_run = 1'b0;
                m_rst_until = m_n + LEN;
                bump();
            end
        end else begin
            m_streak = ls ? m_streak + 1 : 0;
            if (m_streak == LS + 1) begin
                m_run = 1'b1;
            end else if (RETRY && (m_n - m_rst_until == LT)) begin
                m_rst_until = m_n + LEN;
                m_streak = 0;
                bump();
            end
        end
    endfunction

    function automatic logic [10:0] model_out();
        return {(m_n < m_rst_until), !m_run, m_run, 8'(m_relock)};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b required %b", name, $time, act, exp);
        end
    endtask

    // One clock: model advances on the edge, DUT compared on the following falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", dut_vec, model_out());
        if (pll_rst && !prev_pr) rises++;
        prev_pr = pll_rst;
    endtask

    task automatic sync_reset();
        rst_n = 1'b0;
        locked = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        rises = 0;
    endtask

    // Assert reset between edges and check outputs before any clock edge arrives.
    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        check(name, dut_vec, RST_VEC);
        model_reset();
        step();
        rst_n = 1'b1;
        rises = 0;
    endtask

    typedef struct {
        bit          lk;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_left;
        bit val;

        // Power-on sequence: locked rises 2 cycles after pll_rst falls.
        for (int i = 0; i < 17; i++) begin
            tbl[i].lk  = (i >= 5);
            tbl[i].exp = {(i < 3), (i < 15), (i >= 15), 8'd0};
        end

        model_reset();
        rises = 0;
        repeat (3) @(negedge clk);
        check("reset_state", dut_vec, RST_VEC);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            locked = tbl[i].lk;
            step();
            check($sformatf("power_on_edge%0d", i + 1), dut_vec, tbl[i].exp);
        end

        // Lock glitch while STABLE counter is at 5.
        sync_reset();
        for (int e = 1; e <= 24; e++) begin
            locked = (e >= 6 && e != 12);
            step();
            if (e == 22) check("glitch_still_rst", {10'd0, sys_rst}, 11'd1);
            if (e == 23) check("glitch_run", {9'd0, sys_rst, pll_ok}, 11'b01);
        end

        // Lock loss in RUN.
        locked = 1'b0;
        step();
        step();
        check("loss_still_run", {10'd0, pll_ok}, 11'd1);
        step();
        check("loss_resets", {9'd0, pll_rst, sys_rst}, 11'b11);
        begin
            int highs = 1;
            for (int i = 0; i < 10; i++) begin
                step();
                if (pll_rst) highs++;
            end
            check("loss_pulse_len", 11'(highs), 11'(LEN));
        end
        check("loss_relock", {3'd0, relock_cnt}, 11'd1);

        // Asynchronous reset during STABLE, then during RUN.
        sync_reset();
        for (int e = 1; e <= 10; e++) begin
            locked = (e >= 6);
            step();
        end
        async_reset("async_rst_stable");
        for (int e = 1; e <= 20; e++) begin
            locked = (e >= 6);
            step();
        end
        check("run_before_async", {10'd0, pll_ok}, 11'd1);
        async_reset("async_rst_run");

        // Locked held low.
        sync_reset();
`ifdef JTFRAME_PLL_RETRY_EN
        for (int e = 1; e <= 36; e++) step();
        check("retry_first_rise", {10'd0, pll_rst}, 11'd1);
        check("retry_first_cnt", {3'd0, relock_cnt}, 11'd1);
        for (int e = 37; e <= 11000; e++) step();
        check("retry_count", 11'(rises), 11'd305);
        check("retry_saturate", {3'd0, relock_cnt}, 11'd255);
`else
        for (int e = 1; e <= 1000; e++) step();
        check("no_retry_pulses", 11'(rises), 11'd0);
        check("no_retry_relock", {2'd0, pll_rst, relock_cnt}, 11'd0);
`endif

        // Randomised lock behaviour with occasional resets.
        sync_reset();
        run_left = 0;
        val = 1'b0;
        for (int e = 0; e < 4000; e++) begin
            if (run_left == 0) begin
                val = ($urandom_range(0, 3) != 0);
                run_left = val ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
            end
            run_left--;
            locked = val;
            step();
            if ($urandom_range(0, 799) == 0) async_reset("async_rst_random");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
